// File: rtl/rf_alu_pkg.sv
// Shared definitions for the RF_ALU datapath and its command sequencer.
package rf_alu_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  localparam logic CMD_LOAD = 1'b0;
  localparam logic CMD_ALU  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0111;
endpackage

// File: rtl/rf_alu_sequencer.sv
// Sequences RF_ALU through one LOAD or a repeated ALU op per accepted command.
module rf_alu_sequencer
  import rf_alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          Cmd_Valid,
  output logic          Cmd_Ready,
  input  logic          Cmd_Type,
  input  logic [3:0]    Cmd_OP,
  input  logic [AW-1:0] Cmd_A,
  input  logic [AW-1:0] Cmd_B,
  input  logic [AW-1:0] Cmd_D,
  input  logic [DW-1:0] Cmd_Imm,
  input  logic [CW-1:0] Cmd_Count,
  output logic          Write_Reg,
  output logic          Write_Select,
  output logic [AW-1:0] R_Addr_A,
  output logic [AW-1:0] R_Addr_B,
  output logic [AW-1:0] W_Addr,
  output logic [3:0]    OP,
  output logic [DW-1:0] Input_Data,
  input  logic [DW-1:0] ALU_F,
  input  logic          ZF,
  input  logic          CF,
  input  logic          OF,
  input  logic          SF,
  input  logic          PF,
  output logic          Busy,
  output logic          Done,
  output logic [DW-1:0] Result,
  output logic [4:0]    Flags
);

  // is_load is stored active-high so the cleared register yields Write_Select=0
  typedef struct packed {
    logic          is_load;
    logic [3:0]    op;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic [DW-1:0] imm;
  } cmd_t;

  state_t        state, state_nx;
  cmd_t          cmd;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = Cmd_Valid & Cmd_Ready;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state  <= IDLE;
      cmd    <= '0;
      cnt    <= '0;
      Result <= '0;
      Flags  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd <= '{is_load: (Cmd_Type == CMD_LOAD), op: Cmd_OP, a: Cmd_A,
                 b: Cmd_B, d: Cmd_D, imm: Cmd_Imm};
        cnt <= (Cmd_Type == CMD_ALU && Cmd_Count != '0) ? Cmd_Count : CW'(1);
      end else if (state == EXEC) begin
        Result <= cmd.is_load ? cmd.imm : ALU_F;
        if (!cmd.is_load) Flags <= {ZF, CF, OF, SF, PF};
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    Cmd_Ready = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        Cmd_Ready = 1'b1;
        Busy      = 1'b0;
        if (Cmd_Valid) state_nx = EXEC;
      end
      // cnt<=1 rather than ==1 so a corrupted zero count cannot wedge EXEC
      EXEC: if (cnt <= CW'(1)) state_nx = DONE;
      DONE: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // RF_ALU drive holds the last command in IDLE; only the write strobe gates off
  assign Write_Reg    = (state == EXEC) && (cmd.d != '0);
  assign Write_Select = cmd.is_load;
  assign R_Addr_A     = cmd.a;
  assign R_Addr_B     = cmd.b;
  assign W_Addr       = cmd.d;
  assign OP           = cmd.op;
  assign Input_Data   = cmd.imm;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Randomized bench: behavioural RF_ALU beside the DUT plus a command-level reference model.
module tb_rf_alu_sequencer;
  import rf_alu_pkg::*;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Type;
  logic [3:0]  Cmd_OP;
  logic [4:0]  Cmd_A, Cmd_B, Cmd_D;
  logic [31:0] Cmd_Imm;
  logic [3:0]  Cmd_Count;
  logic        Write_Reg, Write_Select;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [3:0]  OP;
  logic [31:0] Input_Data, ALU_F, Result;
  logic        ZF, CF, OF, SF, PF, Busy, Done;
  logic [4:0]  Flags;

  int nvec = 0;
  int nerr = 0;

  always #5 Clk = ~Clk;

  rf_alu_sequencer dut (
    .Clk(Clk), .Clr(Clr), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Type(Cmd_Type), .Cmd_OP(Cmd_OP), .Cmd_A(Cmd_A), .Cmd_B(Cmd_B),
    .Cmd_D(Cmd_D), .Cmd_Imm(Cmd_Imm), .Cmd_Count(Cmd_Count),
    .Write_Reg(Write_Reg), .Write_Select(Write_Select), .R_Addr_A(R_Addr_A),
    .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .OP(OP), .Input_Data(Input_Data),
    .ALU_F(ALU_F), .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .PF(PF),
    .Busy(Busy), .Done(Done), .Result(Result), .Flags(Flags)
  );

  // RF_ALU behaviour: returns {F, ZF, CF, OF, SF, PF}
  function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] f;
    logic cf, of;
    s = '0; f = '0; cf = 1'b0; of = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; f = s[31:0]; cf = s[32];
                    of = (a[31] == b[31]) && (f[31] != a[31]); end
      OP_SUB: begin s = {1'b0, a} - {1'b0, b}; f = s[31:0]; cf = s[32];
                    of = (a[31] != b[31]) && (f[31] != a[31]); end
      OP_OR:  f = a | b;
      OP_XOR: f = a ^ b;
      OP_SHL: f = a << b[4:0];
      default: f = '0;
    endcase
    return {f, (f == 32'd0), cf, of, f[31], ~^f[7:0]};
  endfunction

  logic [31:0] rf [32];
  logic [36:0] alu_out;

  always_comb begin
    alu_out = alu_fn(OP, rf[R_Addr_A], rf[R_Addr_B]);
    ALU_F = alu_out[36:5];
    {ZF, CF, OF, SF, PF} = alu_out[4:0];
  end

  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (Write_Reg && W_Addr != 5'd0) begin
      rf[W_Addr] <= Write_Select ? Input_Data : ALU_F;
    end
  end

  // command-level reference state
  logic [31:0] refm [32];
  logic [4:0]  ref_flags;
  logic [3:0]  ops [5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 32; i++) refm[i] = '0;
    ref_flags = '0;
  endtask

  // Call at a negedge with the DUT idle; returns at the negedge after Done.
  task automatic run_cmd(input logic typ, input logic [3:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic [31:0] imm,
                         input logic [3:0] cnt, input bit hold);
    int n;
    int waits;
    logic [36:0] r;
    logic [31:0] exp_res;
    n = (typ == CMD_ALU) ? ((cnt == 0) ? 1 : int'(cnt)) : 1;
    exp_res = '0;
    for (int i = 0; i < n; i++) begin
      if (typ == CMD_LOAD) exp_res = imm;
      else begin
        r = alu_fn(op, refm[a], refm[b]);
        exp_res = r[36:5];
        ref_flags = r[4:0];
      end
      if (d != 0) refm[d] = exp_res;
    end
    Cmd_Type = typ; Cmd_OP = op; Cmd_A = a; Cmd_B = b; Cmd_D = d;
    Cmd_Imm = imm; Cmd_Count = cnt; Cmd_Valid = 1'b1;
    waits = 0;
    while (!Cmd_Ready && waits < 10) begin @(negedge Clk); waits++; end
    if (!Cmd_Ready) begin
      chk("accept_timeout", 0, 1);
      Cmd_Valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    if (!hold) begin
      // accepted fields must be latched; scramble the bus to prove it
      Cmd_Valid = $urandom_range(0, 1);
      Cmd_Type = $urandom_range(0, 1); Cmd_OP = 4'($urandom);
      Cmd_A = 5'($urandom); Cmd_B = 5'($urandom); Cmd_D = 5'($urandom);
      Cmd_Imm = $urandom; Cmd_Count = 4'($urandom);
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge Clk);
      chk("exec_wr", Write_Reg, (d != 0));
      chk("exec_busy", {Busy, Cmd_Ready, Done}, 3'b100);
      chk("exec_addr", {W_Addr, R_Addr_A, R_Addr_B, OP, Write_Select},
          {d, a, b, op, (typ == CMD_LOAD)});
      if (typ == CMD_LOAD) chk("exec_din", Input_Data, imm);
    end
    @(negedge Clk);
    chk("done_pulse", {Done, Busy, Cmd_Ready, Write_Reg}, 4'b1100);
    chk("result", Result, exp_res);
    chk("flags", Flags, ref_flags);
    Cmd_Valid = 1'b0;
    @(negedge Clk);
    chk("idle_back", {Done, Busy, Cmd_Ready, Write_Reg}, 4'b0010);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {Cmd_Ready, Busy, Done, Write_Reg, Write_Select, R_Addr_A, R_Addr_B,
              W_Addr, OP, Flags}, {4'b1000, 1'b0, 24'd0});
    chk({tag, "_data"}, {Input_Data, Result}, 64'd0);
  endtask

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_OR; ops[3] = OP_XOR; ops[4] = OP_SHL;
    Clr = 1'b1; Cmd_Valid = 1'b0; Cmd_Type = 1'b0; Cmd_OP = '0;
    Cmd_A = '0; Cmd_B = '0; Cmd_D = '0; Cmd_Imm = '0; Cmd_Count = '0;
    ref_clear();
    #3 chk_reset("reset_held");
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    chk_reset("reset_rel");

    // directed sequence
    run_cmd(CMD_LOAD, 4'd0, 5'd0, 5'd0, 5'd1, 32'd7, 4'd0, 0);
    run_cmd(CMD_LOAD, 4'd0, 5'd0, 5'd0, 5'd2, 32'd4, 4'd0, 0);
    run_cmd(CMD_ALU, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 4'd1, 0);
    run_cmd(CMD_ALU, OP_SUB, 5'd2, 5'd1, 5'd4, 32'd0, 4'd1, 0);
    run_cmd(CMD_ALU, OP_SUB, 5'd1, 5'd1, 5'd5, 32'd0, 4'd1, 0);
    run_cmd(CMD_ALU, OP_ADD, 5'd1, 5'd2, 5'd1, 32'd0, 4'd3, 0);
    run_cmd(CMD_ALU, OP_ADD, 5'd1, 5'd2, 5'd6, 32'd0, 4'd0, 0);
    run_cmd(CMD_ALU, OP_XOR, 5'd1, 5'd3, 5'd0, 32'd0, 4'd2, 1);
    run_cmd(CMD_LOAD, 4'd0, 5'd0, 5'd0, 5'd0, 32'hdead_beef, 4'd9, 1);
    run_cmd(CMD_ALU, OP_SHL, 5'd2, 5'd2, 5'd7, 32'd0, 4'd15, 0);

    // random commands, small address space to force read-after-write chains
    for (int t = 0; t < 150; t++) begin
      if (($urandom & 32'd3) == 0) @(negedge Clk);
      run_cmd(1'($urandom), ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
              4'($urandom_range(0, 6)), bit'($urandom_range(0, 1)));
    end

    // Clr in the middle of a 5-iteration command
    Cmd_Type = CMD_ALU; Cmd_OP = OP_ADD; Cmd_A = 5'd1; Cmd_B = 5'd2; Cmd_D = 5'd3;
    Cmd_Imm = 32'h1234; Cmd_Count = 4'd5; Cmd_Valid = 1'b1;
    @(posedge Clk);
    #1 Cmd_Valid = 1'b0;
    @(negedge Clk);
    chk("pre_clr_wr", Write_Reg, 1'b1);
    @(negedge Clk);
    #2 Clr = 1'b1;
    #1 chk_reset("mid_clr");
    @(negedge Clk);
    Clr = 1'b0;
    ref_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("no_done_after_clr", {Done, Busy, Cmd_Ready}, 3'b001);
    end

    for (int t = 0; t < 40; t++) begin
      run_cmd(1'($urandom), ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
              4'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    for (int i = 1; i < 32; i++) chk("rf_final", rf[i], refm[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
